// File: rtl/hazard_unit_mc.sv
// Hazard unit for the F/D/E/M/W pipeline: RAW forwarding into E, load-use
// stalls of LOAD_LAT cycles, multi-cycle execute stalls, branch/jump redirect
// with flush, and a saturating count of cycles in which the PC is held.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow; hazards, redirects and mc ops evaluated here
// LD_STALL | extra load-use stall cycles, ld_cnt counts the remaining ones
// MC_STALL | waiting for the multi-cycle unit to raise mc_done
module hazard_unit_mc #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  d_rs1,
  input  logic [RA_W-1:0]  d_rs2,
  input  logic             d_rs1_used,
  input  logic             d_rs2_used,
  input  logic [RA_W-1:0]  e_rs1,
  input  logic [RA_W-1:0]  e_rs2,
  input  logic [RA_W-1:0]  e_rd,
  input  logic             e_rs1_used,
  input  logic             e_rs2_used,
  input  logic             e_is_load,
  input  logic [RA_W-1:0]  m_rd,
  input  logic             m_we,
  input  logic             m_is_load,
  input  logic [RA_W-1:0]  w_rd,
  input  logic             w_we,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             jump,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             f_d_en,
  output logic             d_e_en,
  output logic             e_m_en,
  output logic             de_bubble,
  output logic             em_bubble,
  output logic             pc_src,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_STALL = 2'd2
  } state_t;

  // The detection cycle is the first stall cycle, so LD_STALL covers the rest.
  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  state_t     state, state_nx;
  logic [2:0] ld_cnt, ld_cnt_nx;
  logic       luh, redirect, mc_wait;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Hazard decode shared by next-state and output logic.
  always_comb begin
    luh = e_is_load && (e_rd != '0) &&
          ((d_rs1_used && (d_rs1 == e_rd)) || (d_rs2_used && (d_rs2 == e_rd)));
    redirect = (branch && branch_taken) || (!branch && jump);
    mc_wait  = mc_start && !mc_done;
  end

  // Forwarding selects; M has priority, a load in M cannot forward yet.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (e_rs1_used && m_we && !m_is_load && (m_rd == e_rs1) && (m_rd != '0))
      fwd_a_raw = 2'b01;
    else if (e_rs1_used && w_we && (w_rd == e_rs1) && (w_rd != '0))
      fwd_a_raw = 2'b10;
    if (e_rs2_used && m_we && !m_is_load && (m_rd == e_rs2) && (m_rd != '0))
      fwd_b_raw = 2'b01;
    else if (e_rs2_used && w_we && (w_rd == e_rs2) && (w_rd != '0))
      fwd_b_raw = 2'b10;
  end

  // State register and load-stall down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      ld_cnt <= 3'd0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
    end
  end

  // Next-state logic; mc_start outranks redirect, redirect outranks luh.
  always_comb begin
    state_nx  = state;
    ld_cnt_nx = ld_cnt;
    case (state)
      RUN: begin
        if (mc_wait) begin
          state_nx = MC_STALL;
        end else if (redirect) begin
          state_nx = RUN;
        end else if (luh && (LOAD_LAT > 1)) begin
          state_nx  = LD_STALL;
          ld_cnt_nx = LD_INIT;
        end
      end
      LD_STALL: begin
        ld_cnt_nx = ld_cnt - 3'd1;
        if (ld_cnt == 3'd1) state_nx = RUN;
      end
      MC_STALL: begin
        if (mc_done) state_nx = RUN;
      end
      default: begin
        state_nx  = RUN;
        ld_cnt_nx = 3'd0;
      end
    endcase
  end

  // Output decode; while reset is asserted every output sits at its idle value.
  always_comb begin
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    pc_en     = 1'b1;
    f_d_en    = 1'b1;
    d_e_en    = 1'b1;
    e_m_en    = 1'b1;
    de_bubble = 1'b0;
    em_bubble = 1'b0;
    pc_src    = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      case (state)
        RUN: begin
          if (mc_wait) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_en    = 1'b0;
            e_m_en    = 1'b0;
            em_bubble = 1'b1;
          end else if (redirect) begin
            pc_src = 1'b1;
            flush  = 1'b1;
          end else if (luh) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            de_bubble = 1'b1;
          end
        end
        LD_STALL: begin
          pc_en     = 1'b0;
          f_d_en    = 1'b0;
          de_bubble = 1'b1;
        end
        MC_STALL: begin
          if (!mc_done) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_en    = 1'b0;
            e_m_en    = 1'b0;
            em_bubble = 1'b1;
          end
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (LOAD_LAT=2/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are checked each cycle against a
// model that tracks remaining stall cycles and multi-cycle busy status.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic       d_rs1_used, d_rs2_used, e_rs1_used, e_rs2_used, e_is_load;
  logic       m_we, m_is_load, w_we, mc_start, mc_done, branch, branch_taken, jump;

  logic [1:0] fwd_a_o[2], fwd_b_o[2];
  logic       pc_en_o[2], f_d_en_o[2], d_e_en_o[2], e_m_en_o[2];
  logic       de_bubble_o[2], em_bubble_o[2], pc_src_o[2], flush_o[2];
  logic [15:0] sc_x;
  logic [3:0]  sc_y;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.RA_W(5), .LOAD_LAT(2), .CNT_W(16)) dut_x (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_rs1_used(e_rs1_used), .e_rs2_used(e_rs2_used), .e_is_load(e_is_load),
    .m_rd(m_rd), .m_we(m_we), .m_is_load(m_is_load), .w_rd(w_rd), .w_we(w_we),
    .mc_start(mc_start), .mc_done(mc_done),
    .branch(branch), .branch_taken(branch_taken), .jump(jump),
    .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]), .pc_en(pc_en_o[0]),
    .f_d_en(f_d_en_o[0]), .d_e_en(d_e_en_o[0]), .e_m_en(e_m_en_o[0]),
    .de_bubble(de_bubble_o[0]), .em_bubble(em_bubble_o[0]),
    .pc_src(pc_src_o[0]), .flush(flush_o[0]), .stall_cycles(sc_x));

  hazard_unit_mc #(.RA_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_y (
    .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_rs1_used(e_rs1_used), .e_rs2_used(e_rs2_used), .e_is_load(e_is_load),
    .m_rd(m_rd), .m_we(m_we), .m_is_load(m_is_load), .w_rd(w_rd), .w_we(w_we),
    .mc_start(mc_start), .mc_done(mc_done),
    .branch(branch), .branch_taken(branch_taken), .jump(jump),
    .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]), .pc_en(pc_en_o[1]),
    .f_d_en(f_d_en_o[1]), .d_e_en(d_e_en_o[1]), .e_m_en(e_m_en_o[1]),
    .de_bubble(de_bubble_o[1]), .em_bubble(em_bubble_o[1]),
    .pc_src(pc_src_o[1]), .flush(flush_o[1]), .stall_cycles(sc_y));

  // Model state: extra load-stall cycles still owed, mc busy flag, stall count.
  int lat[2]  = '{2, 3};
  int cmax[2] = '{65535, 15};
  int ld_left[2];
  bit mc_busy[2];
  int cnt[2];

  function automatic logic [1:0] exp_fwd(logic used, logic [4:0] rs);
    if (!rst || !used || rs == 0) return 2'b00;
    if (m_we && !m_is_load && m_rd == rs) return 2'b01;
    if (w_we && w_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // {pc_en, f_d_en, d_e_en, e_m_en, de_bubble, em_bubble, pc_src, flush}
  function automatic logic [7:0] exp_ctl(int i);
    bit hz, rd;
    hz = e_is_load && e_rd != 0 &&
         ((d_rs1_used && d_rs1 == e_rd) || (d_rs2_used && d_rs2 == e_rd));
    rd = branch ? branch_taken : jump;
    if (!rst) return 8'b1111_0000;
    if (mc_busy[i]) return mc_done ? 8'b1111_0000 : 8'b0000_0100;
    if (ld_left[i] > 0) return 8'b0011_1000;
    if (mc_start && !mc_done) return 8'b0000_0100;
    if (rd) return 8'b1111_0011;
    if (hz) return 8'b0011_1000;
    return 8'b1111_0000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        ld_left[i] <= 0;
        mc_busy[i] <= 1'b0;
        cnt[i]     <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] c;
        c = exp_ctl(i);
        if (!c[7] && cnt[i] < cmax[i]) cnt[i] <= cnt[i] + 1;
        if (mc_busy[i]) begin
          mc_busy[i] <= !mc_done;
        end else if (ld_left[i] > 0) begin
          ld_left[i] <= ld_left[i] - 1;
        end else if (mc_start && !mc_done) begin
          mc_busy[i] <= 1'b1;
        end else if (c[3] && !c[0]) begin
          ld_left[i] <= lat[i] - 1;
        end
      end
    end
  end

  task automatic cmp(input string name, input int i, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, i, $time, act, req);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] c;
      c = exp_ctl(i);
      cmp("fwd_a", i, fwd_a_o[i], exp_fwd(e_rs1_used, e_rs1));
      cmp("fwd_b", i, fwd_b_o[i], exp_fwd(e_rs2_used, e_rs2));
      cmp("ctl", i, {pc_en_o[i], f_d_en_o[i], d_e_en_o[i], e_m_en_o[i],
                     de_bubble_o[i], em_bubble_o[i], pc_src_o[i], flush_o[i]}, c);
    end
    cmp("stall_cycles", 0, sc_x, cnt[0]);
    cmp("stall_cycles", 1, sc_y, cnt[1]);
  end

  task automatic idle();
    {d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd} = '0;
    {d_rs1_used, d_rs2_used, e_rs1_used, e_rs2_used, e_is_load} = '0;
    {m_we, m_is_load, w_we, mc_start, mc_done, branch, branch_taken, jump} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_luh(input logic rs2_used);
    e_is_load = 1'b1; e_rd = 5'd7; d_rs2 = 5'd7; d_rs2_used = rs2_used;
  endtask

  initial begin
    idle();
    // Forwarding-positive inputs during reset must not leak out.
    m_we = 1'b1; m_rd = 5'd5; e_rs1 = 5'd5; e_rs1_used = 1'b1;
    #1;
    cmp("rst_fwd_a", 0, fwd_a_o[0], 0);
    cmp("rst_pc_en", 0, pc_en_o[0], 1);
    step(); step();
    rst = 1'b1;
    #1;
    cmp("fwd_a_m", 0, fwd_a_o[0], 1);
    m_is_load = 1'b1; w_we = 1'b1; w_rd = 5'd5;
    #1;
    cmp("fwd_a_w", 0, fwd_a_o[0], 2);
    e_rs1 = 5'd0; m_rd = 5'd0; m_is_load = 1'b0; w_rd = 5'd0;
    #1;
    cmp("fwd_a_x0", 0, fwd_a_o[0], 0);
    step();
    idle(); e_rs2 = 5'd9; e_rs2_used = 1'b1; m_rd = 5'd9; m_we = 1'b1; w_rd = 5'd9; w_we = 1'b1;
    #1;
    cmp("fwd_b_m", 1, fwd_b_o[1], 1);
    step(); idle();
    step();

    // Load-use stall.
    set_luh(1'b1);
    #1;
    cmp("luh_pc_en", 0, pc_en_o[0], 0);
    cmp("luh_de_bubble", 0, de_bubble_o[0], 1);
    step(); idle();
    #1;
    cmp("ld2_pc_en", 0, pc_en_o[0], 0);
    step();
    cmp("ld_end_pc_en", 0, pc_en_o[0], 1);
    cmp("ld3_pc_en", 1, pc_en_o[1], 0);
    step();
    cmp("ld3_end_pc_en", 1, pc_en_o[1], 1);
    cmp("ld_stall_cnt", 0, sc_x, 2);
    cmp("ld_stall_cnt", 1, sc_y, 3);

    // Masked load-use hazards.
    set_luh(1'b0);
    #1;
    cmp("luh_unused_pc_en", 0, pc_en_o[0], 1);
    step(); idle();
    set_luh(1'b1); branch = 1'b1; branch_taken = 1'b1;
    #1;
    cmp("luh_br_pc_src", 0, pc_src_o[0], 1);
    cmp("luh_br_flush", 0, flush_o[0], 1);
    cmp("luh_br_pc_en", 0, pc_en_o[0], 1);
    step(); idle();
    jump = 1'b1;
    step();
    branch = 1'b1; branch_taken = 1'b0;
    #1;
    cmp("br_nt_jump_pc_src", 0, pc_src_o[0], 0);
    step(); idle();

    // Async reset in the middle of a LOAD_LAT=3 stall.
    set_luh(1'b1);
    step(); idle();
    #2;
    rst = 1'b0;
    #1;
    cmp("async_rst_pc_en", 1, pc_en_o[1], 1);
    cmp("async_rst_cnt", 1, sc_y, 0);
    step(); step();
    rst = 1'b1;
    step();
    set_luh(1'b1);
    #1;
    cmp("post_rst_luh", 1, pc_en_o[1], 0);
    step(); idle();
    step(); step(); step();

    // Multi-cycle op: four stall cycles, then the result advances.
    mc_start = 1'b1;
    #1;
    cmp("mc_e_m_en", 0, e_m_en_o[0], 0);
    cmp("mc_em_bubble", 0, em_bubble_o[0], 1);
    step(); step(); step(); step();
    mc_done = 1'b1;
    #1;
    cmp("mc_done_pc_en", 0, pc_en_o[0], 1);
    cmp("mc_done_e_m_en", 0, e_m_en_o[0], 1);
    step(); idle();

    // Single-cycle completion, then mc_start beating a redirect.
    mc_start = 1'b1; mc_done = 1'b1;
    #1;
    cmp("mc_single_pc_en", 0, pc_en_o[0], 1);
    step(); idle();
    mc_start = 1'b1; jump = 1'b1;
    #1;
    cmp("mc_vs_jump_pc_src", 0, pc_src_o[0], 0);
    step(); jump = 1'b0;

    // Long multi-cycle stall saturates the 4-bit counter.
    for (int k = 0; k < 20; k++) step();
    cmp("sat_cnt", 1, sc_y, 15);
    mc_done = 1'b1;
    step(); idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit. Sits beside the F/D/E/M/W pipeline registers.
- Resolves three kinds of hazard:
  - RAW forwarding into E.
  - Load-use stalls of configurable length.
  - Stalls while a multi-cycle execute unit (mul/div) is busy.
- Generates branch/jump redirect and flush.
- Operand-usage decode is supplied by the decoder rather than recomputed from opcodes.
- Adds x0 filtering and a saturating stall-cycle performance counter.

Parameters:
- RA_W, 5, register address width.
- LOAD_LAT, 1, number of stall cycles inserted for a load-use hazard (legal range 1..7).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- d_rs1, d_rs2  in  RA_W  D-stage source registers.
- d_rs1_used, d_rs2_used  in  1  D instruction reads rs1/rs2.
- e_rs1, e_rs2, e_rd  in  RA_W  E-stage sources and destination.
- e_rs1_used, e_rs2_used  in  1  E instruction reads rs1/rs2.
- e_is_load  in  1  E instruction is a load.
- m_rd  in  RA_W; m_we  in  1; m_is_load  in  1  M-stage destination, write enable, load flag.
- w_rd  in  RA_W; w_we  in  1  W-stage destination and write enable.
- mc_start  in  1  E instruction is a multi-cycle op.
- mc_done  in  1  multi-cycle unit result valid this cycle.
- branch, branch_taken, jump  in  1  E-stage control resolution.
- fwd_a, fwd_b  out  2  forward select for the E operands: 00 none, 01 M, 10 W.
- pc_en, f_d_en, d_e_en, e_m_en  out  1  pipeline register enables.
- de_bubble  out  1  load a NOP into D/E.
- em_bubble  out  1  load a NOP into E/M.
- pc_src  out  1  select the redirect target.
- flush  out  1  squash F/D and D/E.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- FSM states:
  - RUN (reset state).
  - LD_STALL, with a down-counter ld_cnt of 3 bits.
  - MC_STALL.
- While rst=0 (reset asserted):
  - state=RUN, ld_cnt=0, stall_cycles=0.
  - All outputs forced: enables=1, bubbles=0, pc_src=0, flush=0, fwd=00.
  - Reset may assert mid-stall; the FSM returns to RUN immediately (asynchronously).
- Forwarding (combinational, valid in every state):
  - fwd_a=01 if e_rs1_used & m_we & !m_is_load & m_rd==e_rs1 & m_rd!=0.
  - Otherwise fwd_a=10 if e_rs1_used & w_we & w_rd==e_rs1 & w_rd!=0.
  - Otherwise fwd_a=00.
  - fwd_b is identical using rs2. M has priority over W.
- Load-use detection:
  - luh = e_is_load & e_rd!=0 & ((d_rs1_used & d_rs1==e_rd) | (d_rs2_used & d_rs2==e_rd)).
- Control transfer:
  - redirect = (branch & branch_taken) | (!branch & jump).
- RUN, evaluated in this priority order:
  1. mc_start & !mc_done:
     - Outputs: pc_en=f_d_en=d_e_en=e_m_en=0, em_bubble=1, pc_src=flush=0.
     - Next state MC_STALL.
  2. redirect:
     - Outputs: pc_src=1, flush=1, enables=1.
     - The load-use hazard is ignored because the D instruction is wrong-path.
     - Stay in RUN.
  3. luh:
     - Outputs: pc_en=f_d_en=0, d_e_en=1, de_bubble=1.
     - If LOAD_LAT>1: next state LD_STALL, ld_cnt=LOAD_LAT-1.
     - If LOAD_LAT=1: stay in RUN.
     - The stall lasts exactly LOAD_LAT cycles, counting the detection cycle.
  4. Otherwise: all enables=1, bubbles=0.
- LD_STALL:
  - Outputs: pc_en=f_d_en=0, d_e_en=1, de_bubble=1; redirect and luh are not evaluated.
  - ld_cnt decrements each cycle. When ld_cnt==1 at the clock edge, next state is RUN.
- MC_STALL:
  - Outputs: pc_en=f_d_en=d_e_en=e_m_en=0, em_bubble=1, pc_src=flush=0.
  - When mc_done=1: that cycle has all enables=1 and em_bubble=0 (the result advances); next state RUN.
  - A branch/jump held in E cannot coexist with mc_start; the decoder guarantees exclusivity. If both are asserted, mc_start wins.
- mc_start & mc_done in the same RUN cycle (single-cycle completion): no stall.
- stall_cycles increments each cycle pc_en=0 and holds at all-ones (no wrap).
- No combinational path from any input to state other than through the listed decode.

Test Plan:
- Reset: rst=0 mid-LD_STALL with LOAD_LAT=3 → state=RUN, pc_en=1, stall_cycles=0 immediately; after release, normal flow.
- ALU RAW forwarding:
  - m_we=1, m_rd=5, e_rs1=5, e_rs1_used=1 → fwd_a=01.
  - Same with m_is_load=1 and w_we=1, w_rd=5 → fwd_a=10.
  - e_rs1=0, m_rd=0 → fwd_a=00.
- Load-use stall, LOAD_LAT=2: e_is_load=1, e_rd=7, d_rs2=7, d_rs2_used=1 → pc_en=0 and de_bubble=1 for exactly 2 cycles, then pc_en=1; stall_cycles=2.
- Load-use masked by unused operand or redirect:
  - Same as above but d_rs2_used=0 → no stall.
  - luh with branch=1, branch_taken=1 → pc_src=1, flush=1, pc_en=1.
- Multi-cycle op: mc_start=1, mc_done asserted 4 cycles later → all four enables=0 and em_bubble=1 for 4 cycles; enables=1 on the mc_done cycle.
- Counter saturation with CNT_W=4: hold MC_STALL for 20 cycles → stall_cycles=15.
